// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode/direction types and counter limit helper for the PWM engine
package pwm_pkg;
  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;
  function automatic int CNT_MAX(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/pwm_multichannel_if.sv
// pwm_multichannel_if: duty write strobe bus from the register file to the PWM engine
interface pwm_multichannel_if #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8
);
  logic                      duty_wr_en;
  logic [$clog2(NUM_CH)-1:0] duty_wr_ch;
  logic [CNT_W-1:0]          duty_wr_data;
  modport master (output duty_wr_en, duty_wr_ch, duty_wr_data);
  modport slave  (input  duty_wr_en, duty_wr_ch, duty_wr_data);
endinterface

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler, edge/centre counter and period boundary detection
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  center_mode,
  output logic [CNT_W-1:0]      cnt,
  output logic                  boundary
);
  localparam logic [CNT_W-1:0] TOP = CNT_W'(CNT_MAX(CNT_W) - 1);
  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d, presc_act_q, presc_act_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  dir_e                  dir_q, dir_d;
  pwm_mode_e             mode_q, mode_d;
  logic                  tick;
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_q <= '0;
      presc_act_q <= '0;
      cnt_q       <= '0;
      dir_q       <= UP;
      mode_q      <= PWM_EDGE;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      presc_act_q <= presc_act_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
    end
  end
  // centre mode holds cnt for one tick at each turnaround so both ends last two ticks
  always_comb begin
    tick        = presc_cnt_q == presc_act_q;
    presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
    boundary    = tick && (mode_q == PWM_EDGE ? cnt_q == TOP : (dir_q == DOWN && cnt_q == '0));
    cnt_d       = !tick ? cnt_q :
                  mode_q == PWM_EDGE ? (cnt_q == TOP ? '0 : cnt_q + 1'b1) :
                  dir_q == UP ? (cnt_q == TOP ? cnt_q : cnt_q + 1'b1) :
                  (cnt_q == '0 ? cnt_q : cnt_q - 1'b1);
    dir_d       = boundary ? UP :
                  (tick && mode_q == PWM_CENTER && dir_q == UP && cnt_q == TOP) ? DOWN : dir_q;
    mode_d      = boundary ? pwm_mode_e'(center_mode) : mode_q;
    presc_act_d = boundary ? prescale : presc_act_q;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: shadowed per-channel duty registers, compare and registered PWM outputs
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = 16,
  parameter int CNT_W      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     en_out,
  input  logic [NUM_CH-1:0]     en_pwm,
  pwm_multichannel_if.slave     wr,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  center_mode,
  output logic [NUM_CH-1:0]     out,
  output logic                  period_start
);
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [CNT_W-1:0]  duty_act_q [NUM_CH];
  logic [CNT_W-1:0]  duty_act_d [NUM_CH];
  logic [NUM_CH-1:0] out_q, out_d;
  logic              period_start_q, period_start_d;
  logic [CNT_W-1:0]  cnt;
  logic              boundary, wr_hit;
  pwm_timebase #(.CNT_W(CNT_W), .PRESCALE_W(PRESCALE_W)) u_tb (
    .clk         (clk),
    .rst         (rst),
    .prescale    (prescale),
    .center_mode (center_mode),
    .cnt         (cnt),
    .boundary    (boundary)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q       <= '{default: '0};
      duty_act_q     <= '{default: '0};
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      duty_act_q     <= duty_act_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end
  // active duty loads from the post-write shadow so a boundary-cycle write takes effect at once
  always_comb begin
    wr_hit         = wr.duty_wr_en && int'(wr.duty_wr_ch) < NUM_CH;
    period_start_d = boundary;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i]   = (wr_hit && int'(wr.duty_wr_ch) == i) ? wr.duty_wr_data : shadow_q[i];
      duty_act_d[i] = boundary ? shadow_d[i] : duty_act_q[i];
      out_d[i]      = en_out[i] & (en_pwm[i] ? cnt < duty_act_q[i] : 1'b1);
    end
  end
  assign out          = out_q;
  assign period_start = period_start_q;
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: period-position reference model feeding a scoreboard, plus directed duty/timing measurements
module tb_pwm_multichannel;
  localparam int N = 16;
  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] en_out, en_pwm, out;
  logic [7:0]   prescale;
  logic         center_mode, period_start;
  int           tests = 0, fails = 0;
  typedef struct packed {logic [N-1:0] o; logic ps;} exp_t;
  exp_t q[$];
  pwm_multichannel_if #(.NUM_CH(N), .CNT_W(8)) wr ();
  pwm_multichannel dut (
    .clk          (clk),
    .rst          (rst),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .wr           (wr),
    .prescale     (prescale),
    .center_mode  (center_mode),
    .out          (out),
    .period_start (period_start)
  );
  always #5 clk = ~clk;
  // reference model: position k (clks) inside the current period
  int m_k = 0, m_mode = 0, m_presc = 0;
  int m_sh[N], m_act[N];
  function automatic int m_len();
    return (m_mode != 0 ? 510 : 255) * (m_presc + 1);
  endfunction
  function automatic int m_cnt();
    int p;
    p = m_k / (m_presc + 1);
    return m_mode != 0 ? (p < 255 ? p : 509 - p) : p;
  endfunction
  initial begin
    exp_t e;
    int   c;
    logic b;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_k = 0; m_mode = 0; m_presc = 0;
        for (int i = 0; i < N; i++) begin m_sh[i] = 0; m_act[i] = 0; end
        e = '0;
      end else begin
        c = m_cnt();
        for (int i = 0; i < N; i++) e.o[i] = en_out[i] & (en_pwm[i] ? (c < m_act[i]) : 1'b1);
        b = (m_k == m_len() - 1);
        e.ps = b;
        if (wr.duty_wr_en && int'(wr.duty_wr_ch) < N) m_sh[int'(wr.duty_wr_ch)] = int'(wr.duty_wr_data);
        if (b) begin
          for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
          m_mode = int'(center_mode); m_presc = int'(prescale); m_k = 0;
        end else m_k++;
      end
      q.push_back(e);
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (out !== e.o) begin fails++; $display("FAIL out t=%0t got %h exp %h", $time, out, e.o); end
        tests++;
        if (period_start !== e.ps) begin fails++; $display("FAIL period_start t=%0t got %b exp %b", $time, period_start, e.ps); end
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr_duty(input int ch, input int d);
    wr.duty_wr_en = 1'b1; wr.duty_wr_ch = 4'(ch); wr.duty_wr_data = 8'(d);
    @(negedge clk);
    wr.duty_wr_en = 1'b0;
  endtask
  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin fails++; $display("FAIL %s got %0d exp %0d", nm, got, exp); end
  endtask
  task automatic wait_ps(input string nm);
    int w = 0;
    while (!period_start && w < 8000) begin @(negedge clk); w++; end
    check({nm, "_ps_wait"}, int'(period_start), 1);
  endtask
  task automatic measure(input string nm, input int ch, input int n, input int exp_hi, input int exp_ps);
    int hi = 0, ps = 0;
    wait_ps(nm);
    repeat (n) begin @(negedge clk); hi += int'(out[ch]); ps += int'(period_start); end
    check({nm, "_high"}, hi, exp_hi);
    check({nm, "_periods"}, ps, exp_ps);
  endtask
  initial begin
    int w, n;
    rst = 1'b1; en_out = '0; en_pwm = '0; prescale = '0; center_mode = 1'b0;
    wr.duty_wr_en = 1'b0; wr.duty_wr_ch = '0; wr.duty_wr_data = '0;
    cyc(3);
    check("reset_out", int'(out), 0);
    check("reset_ps", int'(period_start), 0);
    rst = 1'b0;
    en_out = '1; en_pwm = 16'hFFF7;
    wr_duty(0, 8'h80); wr_duty(1, 8'h00); wr_duty(2, 8'hFF);
    measure("edge_ch0", 0, 255, 128, 1);
    measure("zero_ch1", 1, 765, 0, 3);
    measure("full_ch2", 2, 765, 765, 3);
    measure("static_ch3", 3, 255, 255, 1);
    center_mode = 1'b1; prescale = 8'd3;
    wr_duty(0, 8'h40);
    wait_ps("centre_load");
    measure("centre_ch0", 0, 2040, 512, 1);
    center_mode = 1'b0; prescale = 8'd0;
    wait_ps("back_edge");
    cyc(2);
    wr_duty(5, 8'h20);
    wait_ps("ch5_load");
    cyc(60);
    wr_duty(5, 8'hC0);
    cyc(120);
    measure("ch5_new", 5, 255, 192, 1);
    w = 0;
    while (m_k != m_len() - 1 && w < 3000) begin @(negedge clk); w++; end
    check("bnd_wait", m_k, m_len() - 1);
    wr_duty(6, 8'hA0);
    cyc(40);
    center_mode = 1'b1; prescale = 8'd1;
    cyc(150);
    for (int i = 0; i < 40; i++) begin
      en_out = 16'($urandom); en_pwm = 16'($urandom);
      cyc(7);
    end
    en_out = '1; en_pwm = '1;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(3) == 0) begin
        n = $urandom_range(3);
        wr.duty_wr_en = 1'b1; wr.duty_wr_ch = 4'($urandom_range(N - 1));
        wr.duty_wr_data = n == 0 ? 8'h00 : n == 1 ? 8'hFF : 8'($urandom);
      end else wr.duty_wr_en = 1'b0;
      if ($urandom_range(49) == 0) begin en_out = 16'($urandom); en_pwm = 16'($urandom); end
      if ($urandom_range(499) == 0) begin center_mode = 1'($urandom); prescale = 8'($urandom_range(2)); end
      @(negedge clk);
    end
    wr.duty_wr_en = 1'b0;
    center_mode = 1'b0; prescale = 8'd0; en_out = '1; en_pwm = '1;
    wr_duty(0, 8'h80);
    w = 0;
    while (!(out[0] && m_act[0] == 8'h80 && m_mode == 0) && w < 8000) begin @(negedge clk); w++; end
    check("pre_rst_high", int'(out[0]), 1);
    cyc(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_out", int'(out), 0);
    check("rst_ps", int'(period_start), 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!period_start && n < 1000);
    check("rst_first_ps", n, 255);
    check("rst_duty_zero", int'(out), 0);
    wr_duty(0, 8'h80);
    wait_ps("restart_load");
    measure("restart_ch0", 0, 255, 128, 1);
    cyc(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
